// File: rtl/sw_poll_pkg.sv
// sw_poll_pkg: FSM state type, PIO register address and event field widths
// shared by the switch poller and its event FIFO.
package sw_poll_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'b00;
    localparam int         SW_W_DEF      = 18;

    // Event word is {changed-mask, new-value}, each SW_W bits wide.
    function automatic int evt_width(input int sw_w);
        return 2 * sw_w;
    endfunction

endpackage

// File: rtl/sw_evt_fifo.sv
// sw_evt_fifo: registered first-word-fall-through FIFO; head reads 0 when empty.
// A push while full is only taken when a pop happens in the same cycle.
module sw_evt_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/sw_poll_ctrl.sv
// sw_poll_ctrl: polls the switch PIO at a fixed rate, debounces samples and queues
// {mask, value} change events. `define SW_POLL_IRQ_EN adds a registered irq output.
module sw_poll_ctrl
    import sw_poll_pkg::*;
#(
    parameter int SW_W       = SW_W_DEF,
    parameter int POLL_DIV   = 50000,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    output logic [1:0]                    pio_address,
    output logic                          pio_read,
    input  logic [31:0]                   pio_readdata,
    output logic [SW_W-1:0]               stable_sw,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [evt_width(SW_W)-1:0]    evt_data,
    output logic                          evt_overflow,
    input  logic                          ovf_clr
`ifdef SW_POLL_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int EVT_W = evt_width(SW_W);
    localparam int DIV_W = $clog2(POLL_DIV);
    localparam int MW    = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 3);
    localparam logic [MW-1:0]    DEB_LAST = MW'(DEB_CNT - 1);

    poll_state_t      state;
    poll_state_t      state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             capture;

    logic [SW_W-1:0]  sample;
    logic [SW_W-1:0]  cand;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    cnt_n;
    logic             commit;
    logic             drop;
    logic [EVT_W-1:0] evt_word;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             unused_bits;

    assign pio_address = PIO_DATA_ADDR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_WAIT;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
        end
    end

    // WAIT + REQ + CAP spans POLL_DIV cycles, so WAIT terminates at POLL_DIV-3.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        pio_read  = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (enable) begin
                    if (div_cnt == DIV_LAST) begin
                        state_nxt = S_REQ;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = div_cnt + 1'b1;
                    end
                end
            end
            S_REQ: begin
                pio_read  = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                capture   = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign sample      = pio_readdata[SW_W-1:0];
    assign unused_bits = ^{pio_readdata[31:SW_W], fifo_count};

    always_comb begin
        cnt_n = '0;
        if (sample == cand)
            cnt_n = (match_cnt == DEB_LAST) ? match_cnt : match_cnt + 1'b1;
    end

    assign commit   = capture && (cnt_n == DEB_LAST) && (sample != stable_sw);
    assign evt_word = {sample ^ stable_sw, sample};
    assign drop     = commit && fifo_full && !evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand         <= '0;
            match_cnt    <= '0;
            stable_sw    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (capture) begin
                cand      <= sample;
                match_cnt <= cnt_n;
            end
            if (commit) stable_sw <= sample;
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (drop)
                evt_overflow <= 1'b1;
            else if (ovf_clr)
                evt_overflow <= 1'b0;
        end
    end

    sw_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (commit),
        .pop     (evt_ready),
        .data_in (evt_word),
        .head    (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign evt_valid = ~fifo_empty;

`ifdef SW_POLL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= ~fifo_empty | evt_overflow;
    end
`endif

endmodule

// File: tb/tb_sw_poll_ctrl.sv
// tb_sw_poll_ctrl: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the sampling schedule, debounce and event FIFO.
module tb_sw_poll_ctrl;

    localparam int SW_W       = 18;
    localparam int POLL_DIV   = 8;
    localparam int DEB_CNT    = 3;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        evt_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_read;
    logic [31:0] pio_readdata;
    logic [17:0] stable_sw;
    logic        evt_valid;
    logic [35:0] evt_data;
    logic        evt_overflow;
`ifdef SW_POLL_IRQ_EN
    logic        irq;
`endif

    logic [17:0] sw = '0;
    logic [17:0] last_val;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sw_poll_ctrl #(
        .SW_W       (SW_W),
        .POLL_DIV   (POLL_DIV),
        .DEB_CNT    (DEB_CNT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .pio_address  (pio_address),
        .pio_read     (pio_read),
        .pio_readdata (pio_readdata),
        .stable_sw    (stable_sw),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
`ifdef SW_POLL_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    // PIO slave: readdata registered one cycle after the read strobe; upper bits are junk.
    logic [31:0] rnd;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_readdata <= '0;
        end else if (pio_read) begin
            rnd = $urandom;
            pio_readdata <= {rnd[31:18], sw};
        end
    end

    // Reference model: ph is the position within the sample period.
    int          ph = 0;
    int          n_samples = 0;
    logic [17:0] hist[$];
    logic [35:0] mq[$];
    logic [17:0] m_stable = '0;
    logic        m_ovf = 1'b0;
    logic        m_irq = 1'b0;
    logic [17:0] s;
    logic [35:0] ev;
    bit          popping, push, drop, all_eq, pre_ne, pre_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph = 0;
            hist.delete();
            mq.delete();
            m_stable = '0;
            m_ovf = 1'b0;
            m_irq = 1'b0;
        end else begin
            pre_ne  = mq.size() > 0;
            pre_ovf = m_ovf;
            popping = evt_ready && pre_ne;
            push    = 1'b0;
            drop    = 1'b0;
            if (ph == POLL_DIV - 1) begin
                s = pio_readdata[17:0];
                hist.push_back(s);
                if (hist.size() > DEB_CNT) void'(hist.pop_front());
                all_eq = (hist.size() == DEB_CNT);
                foreach (hist[i]) if (hist[i] !== s) all_eq = 1'b0;
                if (all_eq && s !== m_stable) begin
                    ev = {s ^ m_stable, s};
                    m_stable = s;
                    push = 1'b1;
                end
                n_samples++;
            end
            if (popping) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(ev);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_irq = pre_ne || pre_ovf;
            if (ph < POLL_DIV - 2) begin
                if (enable) ph++;
            end else if (ph == POLL_DIV - 1) begin
                ph = 0;
            end else begin
                ph++;
            end
        end
    end

    task automatic wait_samples(input int k);
        int target = n_samples + k;
        for (int i = 0; i < k * POLL_DIV * 8 && n_samples < target; i++) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 4 * POLL_DIV && ph != p; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int cyc;
        reset_n = 1'b0; enable = 1'b1; sw = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({pio_read, evt_valid, evt_data, evt_overflow, stable_sw} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b v=%b d=%h o=%b s=%h, expected all 0",
                     pio_read, evt_valid, evt_data, evt_overflow, stable_sw);
        end
        n_tests++;
        if (pio_address !== 2'b00) begin
            n_fail++;
            $display("FAIL pio_address: got %b expected 00", pio_address);
        end
        reset_n = 1'b1;
        cyc = 0;
        while (!pio_read && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== POLL_DIV - 2) begin
            n_fail++;
            $display("FAIL first_read_cycle: got %0d expected %0d", cyc, POLL_DIV - 2);
        end
    endtask

    task automatic test_step();
        sw = 18'h00005;
        for (int k = 1; k <= 3; k++) begin
            wait_samples(1);
            n_tests++;
            if (k < 3 && (evt_valid !== 1'b0 || stable_sw !== '0)) begin
                n_fail++;
                $display("FAIL step_early_%0d: got v=%b s=%h expected v=0 s=0", k, evt_valid, stable_sw);
            end else if (k == 3 && (evt_valid !== 1'b1 || stable_sw !== 18'h5 ||
                                    evt_data !== {18'h5, 18'h5})) begin
                n_fail++;
                $display("FAIL step_commit: got v=%b s=%h d=%h expected v=1 s=00005 d=%h",
                         evt_valid, stable_sw, evt_data, {18'h5, 18'h5});
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        wait_phase(POLL_DIV - 1);
        n_tests++;
        if (evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_before_reset: got v=%b expected 1", evt_valid);
        end
        #2 reset_n = 1'b0;
        sw = '0;
        #1;
        n_tests++;
        if ({pio_read, evt_valid, evt_data, evt_overflow, stable_sw} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got rd=%b v=%b d=%h o=%b s=%h expected all 0",
                     pio_read, evt_valid, evt_data, evt_overflow, stable_sw);
        end
`ifdef SW_POLL_IRQ_EN
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_irq: got %b expected 0", irq);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        while (!pio_read && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== POLL_DIV - 2) begin
            n_fail++;
            $display("FAIL reset_mid_first_read: got %0d expected %0d", cyc, POLL_DIV - 2);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 12; i++) begin
            sw = (i % 2 == 0) ? 18'h1 : 18'h0;
            wait_samples(1);
            n_tests++;
            if (evt_valid !== 1'b0 || stable_sw !== '0) begin
                n_fail++;
                $display("FAIL bounce_%0d: got v=%b s=%h expected v=0 s=0", i, evt_valid, stable_sw);
            end
        end
        sw = 18'h3FFFF;
        wait_samples(2);
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_hold_early: got v=%b expected 0", evt_valid);
        end
        wait_samples(1);
        n_tests++;
        if (evt_valid !== 1'b1 || evt_data !== {18'h3FFFF, 18'h3FFFF} || stable_sw !== 18'h3FFFF) begin
            n_fail++;
            $display("FAIL bounce_commit: got v=%b d=%h s=%h expected v=1 d=%h s=3ffff",
                     evt_valid, evt_data, stable_sw, {18'h3FFFF, 18'h3FFFF});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_single_event: got v=%b after pop expected 0", evt_valid);
        end
        last_val = 18'h3FFFF;
    endtask

    task automatic test_overflow();
        logic [35:0] exp_q[$];
        logic [17:0] v;
        logic [17:0] prev = last_val;
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = 18'($urandom);
            while (v == prev) v = 18'($urandom);
            exp_q.push_back({v ^ prev, v});
            prev = v;
            sw = v;
            wait_samples(3);
        end
        n_tests++;
        if (evt_overflow !== 1'b1 || stable_sw !== prev || evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got o=%b s=%h v=%b expected o=1 s=%h v=1",
                     evt_overflow, stable_sw, evt_valid, prev);
        end
        // Drop and ovf_clr on the same edge: the drop wins.
        v = 18'($urandom);
        while (v == prev) v = 18'($urandom);
        prev = v;
        sw = v;
        wait_samples(2);
        wait_phase(POLL_DIV - 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_tests++;
        if (evt_overflow !== 1'b1 || stable_sw !== prev) begin
            n_fail++;
            $display("FAIL drop_beats_clear: got o=%b s=%h expected o=1 s=%h", evt_overflow, stable_sw, prev);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (evt_data !== exp_q[k] || evt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_order_%0d: got v=%b d=%h expected v=1 d=%h", k, evt_valid, evt_data, exp_q[k]);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        n_tests++;
        if (evt_valid !== 1'b0 || evt_data !== '0) begin
            n_fail++;
            $display("FAIL drained_empty: got v=%b d=%h expected v=0 d=0", evt_valid, evt_data);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_tests++;
        if (evt_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", evt_overflow);
        end
`ifdef SW_POLL_IRQ_EN
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_clear: got %b expected 0", irq);
        end
`endif
        last_val = prev;
    endtask

    task automatic test_full_pushpop();
        logic [35:0] exp_q[$];
        logic [35:0] want;
        logic [17:0] v;
        logic [17:0] prev = last_val;
        int pops;
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = 18'($urandom);
            while (v == prev) v = 18'($urandom);
            exp_q.push_back({v ^ prev, v});
            prev = v;
            sw = v;
            if (k < 4) begin
                wait_samples(3);
            end else begin
                wait_samples(2);
                wait_phase(POLL_DIV - 1);
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end
        end
        n_tests++;
        if (evt_overflow !== 1'b0 || stable_sw !== prev || evt_data !== exp_q[1]) begin
            n_fail++;
            $display("FAIL full_pushpop: got o=%b s=%h d=%h expected o=0 s=%h d=%h",
                     evt_overflow, stable_sw, evt_data, prev, exp_q[1]);
        end
        pops = 0;
        while (evt_valid && pops < 6) begin
            want = (pops + 1 < 5) ? exp_q[pops + 1] : '0;
            n_tests++;
            if (evt_data !== want) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got %h expected %h", pops, evt_data, want);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
            pops++;
`ifdef SW_POLL_IRQ_EN
            n_tests++;
            if (irq !== 1'b1) begin
                n_fail++;
                $display("FAIL irq_during_drain_%0d: got %b expected 1", pops, irq);
            end
`endif
        end
        n_tests++;
        if (pops !== 4) begin
            n_fail++;
            $display("FAIL full_count: got %0d entries expected 4", pops);
        end
`ifdef SW_POLL_IRQ_EN
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_last_pop: got %b expected 0", irq);
        end
`endif
        last_val = prev;
    endtask

    task automatic test_enable();
        int highs = 0;
        int cyc;
        wait_phase(2);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pio_read) highs++;
        end
        n_tests++;
        if (highs !== 0) begin
            n_fail++;
            $display("FAIL disabled_reads: got %0d strobes expected 0", highs);
        end
        enable = 1'b1;
        cyc = 0;
        while (!pio_read && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== POLL_DIV - 2 - 2) begin
            n_fail++;
            $display("FAIL resume_held_count: got %0d expected %0d", cyc, POLL_DIV - 4);
        end
        @(posedge clk); #1;
        cyc = 1;
        while (!pio_read && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc !== POLL_DIV) begin
            n_fail++;
            $display("FAIL sample_period: got %0d expected %0d", cyc, POLL_DIV);
        end
    endtask

    task automatic test_random();
        logic [17:0] pool [4];
        logic [35:0] exp_head;
        for (int i = 0; i < 4; i++) pool[i] = 18'($urandom);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp_head = (mq.size() > 0) ? mq[0] : '0;
            n_tests++;
            if (pio_read !== (ph == POLL_DIV - 2) || stable_sw !== m_stable ||
                evt_valid !== (mq.size() > 0) || evt_data !== exp_head || evt_overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_c%0d: got rd=%b s=%h v=%b d=%h o=%b expected rd=%b s=%h v=%b d=%h o=%b",
                         c, pio_read, stable_sw, evt_valid, evt_data, evt_overflow,
                         ph == POLL_DIV - 2, m_stable, mq.size() > 0, exp_head, m_ovf);
            end
`ifdef SW_POLL_IRQ_EN
            n_tests++;
            if (irq !== m_irq) begin
                n_fail++;
                $display("FAIL random_irq_c%0d: got %b expected %b", c, irq, m_irq);
            end
`endif
            if (ph == 0 && $urandom_range(0, 9) < 4) sw = pool[$urandom_range(0, 3)];
            evt_ready = ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            enable    = ($urandom_range(0, 7) != 0);
        end
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_step();
        test_reset_mid();
        test_bounce();
        test_overflow();
        test_full_pushpop();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
